// File: rtl/x3q16_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package x3q16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [15:0] ABORT_DATA = 16'hFFFF;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One-deep pending request slot for a single requester, with sticky overrun detect.
module mem_arb_slot
  import x3q16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        req_type_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_data_i,
  input  logic        free_i,
  output logic        pending_o,
  output req_t        slot_o,
  output logic        overrun_o
);

  logic full_q, full_d;
  logic overrun_q, overrun_d;
  req_t data_q, data_d;
  req_t incoming;

  assign incoming.write = req_type_i;
  assign incoming.addr  = req_addr_i;
  assign incoming.data  = req_data_i;

  // A fresh pulse counts as pending immediately so IDLE can grant it on the capture edge.
  assign pending_o = full_q | req_i;
  assign slot_o    = full_q ? data_q : incoming;
  assign overrun_o = overrun_q;

  always_comb begin
    full_d    = full_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (req_i) begin
      if (full_q) begin
        overrun_d = 1'b1;
      end else begin
        full_d = 1'b1;
        data_d = incoming;
      end
    end
    if (free_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      full_q    <= full_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA requesters onto one shared memory port with
// fair priority, per-transfer timeout and registered response pulses.
module mem_arbiter
  import x3q16_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_request,
  input  logic        cpu_request_type,
  input  logic [15:0] cpu_request_address,
  input  logic [15:0] cpu_data_out,
  output logic [15:0] cpu_memory_in,
  output logic        cpu_memory_ready,
  output logic        cpu_write_complete,
  input  logic        dma_request,
  input  logic        dma_request_type,
  input  logic [15:0] dma_request_address,
  input  logic [15:0] dma_data_out,
  output logic [15:0] dma_memory_in,
  output logic        dma_memory_ready,
  output logic        dma_write_complete,
  output logic        mem_request,
  output logic        mem_request_type,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  input  logic [15:0] mem_memory_in,
  input  logic        mem_memory_ready,
  input  logic        mem_write_complete,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic cpu_pending, dma_pending, cpu_overrun, dma_overrun, cpu_free, dma_free;
  req_t cpu_slot, dma_slot, grant_slot;

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_type_q, mem_type_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic        cpu_ready_q, cpu_ready_d, cpu_wdone_q, cpu_wdone_d;
  logic        dma_ready_q, dma_ready_d, dma_wdone_q, dma_wdone_d;
  logic        timeout_q, timeout_d;

  logic any_pending, grant_port, done, abort, finish, other_pending;

  mem_arb_slot u_cpu_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (cpu_request),
    .req_type_i (cpu_request_type),
    .req_addr_i (cpu_request_address),
    .req_data_i (cpu_data_out),
    .free_i     (cpu_free),
    .pending_o  (cpu_pending),
    .slot_o     (cpu_slot),
    .overrun_o  (cpu_overrun)
  );

  mem_arb_slot u_dma_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (dma_request),
    .req_type_i (dma_request_type),
    .req_addr_i (dma_request_address),
    .req_data_i (dma_data_out),
    .free_i     (dma_free),
    .pending_o  (dma_pending),
    .slot_o     (dma_slot),
    .overrun_o  (dma_overrun)
  );

  assign any_pending   = cpu_pending | dma_pending;
  assign grant_port    = (cpu_pending && dma_pending) ? prio_q :
                         (dma_pending ? PORT_DMA : PORT_CPU);
  assign grant_slot    = (grant_port == PORT_DMA) ? dma_slot : cpu_slot;
  assign done          = (state_q == ST_WAIT) &&
                         (mem_type_q ? mem_write_complete : mem_memory_ready);
  assign abort         = (state_q == ST_WAIT) && !done && ((cnt_q + 8'd1) == TIMEOUT_CNT);
  assign finish        = done | abort;
  assign other_pending = (owner_q == PORT_CPU) ? dma_pending : cpu_pending;
  assign cpu_free      = finish && (owner_q == PORT_CPU);
  assign dma_free      = finish && (owner_q == PORT_DMA);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_pending) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (finish) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_wdone_d = 1'b0;
    dma_ready_d = 1'b0;
    dma_wdone_d = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          owner_d    = grant_port;
          mem_req_d  = 1'b1;
          mem_type_d = grant_slot.write;
          mem_addr_d = grant_slot.addr;
          mem_data_d = grant_slot.data;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (finish) begin
          timeout_d = abort;
          // Priority passes to the other port only if it was kept waiting.
          if (other_pending) prio_d = ~owner_q;
          if (owner_q == PORT_CPU) begin
            cpu_ready_d = ~mem_type_q;
            cpu_wdone_d = mem_type_q;
            if (!mem_type_q) cpu_rdata_d = done ? mem_memory_in : ABORT_DATA;
          end else begin
            dma_ready_d = ~mem_type_q;
            dma_wdone_d = mem_type_q;
            if (!mem_type_q) dma_rdata_d = done ? mem_memory_in : ABORT_DATA;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q     <= PORT_CPU;
      prio_q      <= PORT_CPU;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_type_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_wdone_q <= 1'b0;
      dma_ready_q <= 1'b0;
      dma_wdone_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_wdone_q <= cpu_wdone_d;
      dma_ready_q <= dma_ready_d;
      dma_wdone_q <= dma_wdone_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_request        = mem_req_q;
  assign mem_request_type   = mem_type_q;
  assign mem_address        = mem_addr_q;
  assign mem_data           = mem_data_q;
  assign cpu_memory_in      = cpu_rdata_q;
  assign cpu_memory_ready   = cpu_ready_q;
  assign cpu_write_complete = cpu_wdone_q;
  assign dma_memory_in      = dma_rdata_q;
  assign dma_memory_ready   = dma_ready_q;
  assign dma_write_complete = dma_wdone_q;
  assign timeout_err        = timeout_q;
  assign overrun_err        = cpu_overrun | dma_overrun;

endmodule
